// File: rtl/prefetch_pkg.sv
// Shared definitions for the instruction prefetch queue: default geometry,
// derived widths, window byte typedefs and the control FSM encoding.
package prefetch_pkg;

  localparam int DEF_DEPTH_BYTES  = 16;
  localparam int DEF_WINDOW_BYTES = 8;

  // Widths for the default geometry; modules re-derive them from their own parameters.
  localparam int PTR_W     = $clog2(DEF_DEPTH_BYTES);
  localparam int CNT_W     = PTR_W + 1;
  localparam int CONSUME_W = $clog2(DEF_WINDOW_BYTES) + 1;

  typedef logic [7:0] byte_t;
  typedef byte_t window_t [0:DEF_WINDOW_BYTES-1];

  typedef enum logic {
    REFILL = 1'b0,
    STREAM = 1'b1
  } pq_state_e;

endpackage

// File: rtl/prefetch_byte_ring.sv
// Circular byte storage for the prefetch queue: word writes with a leading
// byte skip, a variable-length read advance and the decode window mux.
module prefetch_byte_ring
  import prefetch_pkg::*;
#(
  parameter int DEPTH_BYTES  = DEF_DEPTH_BYTES,
  parameter int WINDOW_BYTES = DEF_WINDOW_BYTES,
  localparam int RPTR_W = $clog2(DEPTH_BYTES),
  localparam int RCNT_W = RPTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_skip_i,
  input  logic [31:0]       wr_data_i,
  input  logic [RCNT_W-1:0] rd_adv_i,
  input  logic [RCNT_W-1:0] win_count_i,
  output byte_t             window_o [0:WINDOW_BYTES-1]
);

  byte_t             mem_q [DEPTH_BYTES];
  logic [RPTR_W-1:0] wr_q, wr_d;
  logic [RPTR_W-1:0] rd_q, rd_d;

  // Pointer next-state: both wrap naturally at DEPTH_BYTES.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q + RPTR_W'(rd_adv_i);
    if (wr_en_i) wr_d = wr_q + RPTR_W'(3'd4 - {1'b0, wr_skip_i});
  end

  // Pointers return to zero on reset or flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Write bytes skip..3 of the word contiguously starting at the write pointer.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (2'(b) >= wr_skip_i)
          mem_q[wr_q + RPTR_W'(b) - RPTR_W'(wr_skip_i)] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Window mux: oldest byte first, zero beyond the valid byte count.
  always_comb begin
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      window_o[k] = 8'h00;
      if (RCNT_W'(k) < win_count_i) window_o[k] = mem_q[rd_q + RPTR_W'(k)];
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: tracks byte count, first-word skip and the
// linear fetch address, runs the fill handshake and flags consume underflow.
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int          DEPTH_BYTES   = DEF_DEPTH_BYTES,
  parameter int          WINDOW_BYTES  = DEF_WINDOW_BYTES,
  parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0,
  localparam int QCNT_W = $clog2(DEPTH_BYTES) + 1,
  localparam int QCON_W = $clog2(WINDOW_BYTES) + 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic [31:0]       i_flush_address,
  output logic [31:0]       o_fetch_address,
  output logic              o_fill_ready,
  input  logic              i_fill_valid,
  input  logic [31:0]       i_fill_data,
  output byte_t             o_window [0:WINDOW_BYTES-1],
  output logic [QCNT_W-1:0] o_window_count,
  input  logic [QCON_W-1:0] i_consume_count,
  output logic              o_underflow
);

  logic [QCNT_W-1:0] count_q, count_d;
  logic [1:0]        skip_q;
  logic [31:0]       addr_q;
  logic              underflow_q;
  pq_state_e         state_q;

  logic              transfer;
  logic [2:0]        written;
  logic [QCNT_W-1:0] win_cnt;
  logic [QCNT_W-1:0] consumed;
  logic              over;

  // Ready depends only on the registered count, so a same-cycle consume never raises it.
  assign o_fill_ready = (count_q <= QCNT_W'(DEPTH_BYTES - 4));
  assign transfer     = i_fill_valid & o_fill_ready;
  assign written      = transfer ? (3'd4 - {1'b0, skip_q}) : 3'd0;

  // Visible bytes and clamped consume; a consume beyond the window is an underflow.
  always_comb begin
    win_cnt = '0;
    if (state_q == STREAM)
      win_cnt = (count_q > QCNT_W'(WINDOW_BYTES)) ? QCNT_W'(WINDOW_BYTES) : count_q;
    over     = 32'(i_consume_count) > 32'(win_cnt);
    consumed = over ? win_cnt : QCNT_W'(i_consume_count);
    count_d  = count_q + QCNT_W'(written) - consumed;
  end

  // Control state: reset beats flush, flush discards any same-cycle fill/consume.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q     <= '0;
      skip_q      <= RESET_ADDRESS[1:0];
      addr_q      <= {RESET_ADDRESS[31:2], 2'b00};
      underflow_q <= 1'b0;
      state_q     <= REFILL;
    end else if (i_flush) begin
      count_q <= '0;
      skip_q  <= i_flush_address[1:0];
      addr_q  <= {i_flush_address[31:2], 2'b00};
      state_q <= REFILL;
    end else begin
      count_q <= count_d;
      if (transfer) begin
        skip_q <= 2'd0;
        addr_q <= addr_q + 32'd4;
      end
      if (over) underflow_q <= 1'b1;
      case (state_q)
        REFILL:  if (transfer) state_q <= STREAM;
        STREAM:  if (count_d == '0) state_q <= REFILL;
        default: state_q <= REFILL;
      endcase
    end
  end

  prefetch_byte_ring #(
    .DEPTH_BYTES  (DEPTH_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_ring (
    .clk_i       (i_clock),
    .rst_i       (i_reset),
    .clear_i     (i_flush),
    .wr_en_i     (transfer & ~i_flush & ~i_reset),
    .wr_skip_i   (skip_q),
    .wr_data_i   (i_fill_data),
    .rd_adv_i    (consumed),
    .win_count_i (win_cnt),
    .window_o    (o_window)
  );

  assign o_fetch_address = addr_q;
  assign o_window_count  = win_cnt;
  assign o_underflow     = underflow_q;

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction byte queue between the bus/fetch unit and the decode front end (prefix decoder, opcode decoder).
- Accepts 32-bit code words from the bus unit and keeps a circular byte buffer.
- Presents a byte-aligned window of the oldest bytes to decode; decode retires a variable number of bytes per cycle.
- Generates the linear fetch address and handles flush/redirect on control transfer, including an unaligned branch target.

Parameters:
- DEPTH_BYTES, 16, queue capacity in bytes; power of two, at least 8.
- WINDOW_BYTES, 8, number of bytes presented to decode; at most DEPTH_BYTES.
- RESET_ADDRESS, 32'hFFFF_FFF0, fetch address after reset.

Ports:
- i_clock  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  discard the queue contents and redirect fetch.
- i_flush_address  in  32  new linear fetch address; sampled when i_flush=1.
- o_fetch_address  out  32  word-aligned address of the next word requested (bits[1:0]=0).
- o_fill_ready  out  1  queue can accept one 4-byte word this cycle.
- i_fill_valid  in  1  bus unit presents a word.
- i_fill_data  in  32  code word; byte0 = bits[7:0] = lowest address.
- o_window  out  8xWINDOW_BYTES  unpacked array [0:WINDOW_BYTES-1]; element 0 = oldest byte.
- o_window_count  out  $clog2(DEPTH_BYTES)+1  number of valid bytes in the window, min(count, WINDOW_BYTES).
- i_consume_count  in  $clog2(WINDOW_BYTES)+1  bytes retired by decode this cycle.
- o_underflow  out  1  registered sticky error: a consume exceeded the valid bytes.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - count=0, read/write pointers=0, skip=0.
  - o_fetch_address=RESET_ADDRESS with bits[1:0] forced to 0, and skip=RESET_ADDRESS[1:0].
  - o_underflow=0, o_fill_ready=1 (DEPTH_BYTES>=4).
  - o_window elements all 8'h00, o_window_count=0.
- Fill handshake:
  - A transfer occurs when i_fill_valid & o_fill_ready.
  - o_fill_ready = (DEPTH_BYTES - count) >= 4, computed from the registered count only. A same-cycle consume does not raise ready.
  - On transfer, bytes skip..3 of i_fill_data are written at the write pointer, and count increases by 4-skip.
  - Also on transfer: skip becomes 0 and o_fetch_address increments by 4. Wrap from 32'hFFFF_FFFC goes to 0 (modulo 2^32).
  - i_fill_data is ignored when no transfer occurs.
- Consume:
  - i_consume_count bytes are removed from the head; the read pointer advances modulo DEPTH_BYTES.
  - If i_consume_count > o_window_count, the consume is clamped to o_window_count and o_underflow is set. It is cleared only by reset.
  - i_consume_count > WINDOW_BYTES is treated the same way (clamped, underflow set).
- Same-cycle fill and consume: count_next = count + written - consumed. Both are applied; written bytes are never visible in the window in the same cycle.
- Window:
  - Combinational from the registered state.
  - o_window[k] = buffer[(rd+k) mod DEPTH_BYTES] for k < o_window_count; otherwise 8'h00.
  - The window is valid one cycle after the write edge (latency fill→window = 1 clock).
- Flush:
  - Priority is reset > flush > fill/consume.
  - On i_flush: count=0, rd=wr=0, o_fetch_address={i_flush_address[31:2],2'b00}, skip=i_flush_address[1:0].
  - Any fill or consume presented in the same cycle is discarded.
  - o_underflow is not cleared by flush.
- Two-state control FSM:
  - REFILL: count=0 after flush/reset; o_window_count=0.
  - STREAM: count>0.
  - REFILL→STREAM on the first transfer; STREAM→REFILL when count_next=0 or on flush.
- Boundaries:
  - Full queue: ready=0 and the bus must hold its word.
  - Pointer wrap is modulo DEPTH_BYTES via natural width overflow.
  - A skip=3 first word adds exactly 1 byte.
  - Reset asserted mid-stream overrides everything in that cycle.

Decomposition:
- Shared package prefetch_pkg holds:
  - default DEPTH_BYTES/WINDOW_BYTES constants;
  - the count/pointer width localparams;
  - typedef for the window byte array;
  - the FSM state enum {REFILL, STREAM}.
- Sub-module prefetch_byte_ring:
  - contains the storage array, read/write pointers and the window mux;
  - the top level holds count, skip, fetch address, FSM, handshake and error logic.

Test Plan:
- Reset, then fills 0x04030201 and 0x08070605, no consume:
  - o_fetch_address goes FFFFFFF0→F4→F8;
  - window = 01..08 with o_window_count=8 one cycle after the second fill.
- Steady state with count=8, consume 3 and a concurrent fill of 0x0C0B0A09:
  - next cycle window[0]=04, o_window_count=8;
  - internal count=9.
- Flush to 0x00001003, then fill 0xDDCCBBAA:
  - only byte DD is written, o_window_count=1, window[0]=DD;
  - o_fetch_address=0x00001004.
- Fill until count=16:
  - o_fill_ready=0; an asserted i_fill_valid is held and not written;
  - after consuming 4, o_fill_ready=1 on the next cycle.
- Count=2, consume 5:
  - count becomes 0, o_underflow=1 and it stays 1 through a later flush;
  - reset clears it.
- Flush, fill and consume asserted in the same cycle:
  - count=0 and the fill data is discarded;
  - o_fetch_address equals the flush target aligned down.
